// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - redirect handshake between branch_ctrl and fetch
interface branch_ctrl_if;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;

  modport master (output redir_valid, output redir_pc, input redir_ready);
  modport slave  (input redir_valid, input redir_pc, output redir_ready);
endinterface

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - execute-stage control-flow sequencer with fetch redirect and squash
// Optional statistics counters enabled by defining BRANCH_CTRL_STATS_EN.
module branch_ctrl #(
  parameter int unsigned FETCH_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jal,
  input  logic                 ex_is_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_imm,
  input  logic [31:0]          ex_rs1_data,
  input  logic [31:0]          ex_rs2_data,
  output logic                 br_en,
  output logic [2:0]           br_funct3,
  output logic [31:0]          br_data_a,
  output logic [31:0]          br_data_b,
  input  logic                 br_taken,
  output logic [31:0]          link_data,
  branch_ctrl_if.master        redir,
  output logic                 flush,
  output logic                 misalign_exc,
  output logic [31:0]          misalign_tval,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_taken,
  output logic [31:0]          stat_stall
);

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  state_t      state;
  logic [3:0]  drain_cnt;
  logic        accept;
  logic        taken;
  logic        misaligned;
  logic [31:0] target;

  assign ex_ready   = (state == IDLE);
  assign accept     = ex_valid & ex_ready;
  assign br_en      = accept & ex_is_branch;
  assign br_funct3  = ex_funct3;
  assign br_data_a  = ex_rs1_data;
  assign br_data_b  = ex_rs2_data;
  assign link_data  = ex_pc + 32'd4;

  assign taken      = ex_is_jal | ex_is_jalr | (ex_is_branch & br_taken);
  assign target     = ex_is_jalr ? ((ex_rs1_data + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
  assign misaligned = (target[1:0] != 2'b00);

  // flush is high on the first REDIRECT cycle and on every DRAIN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      drain_cnt         <= 4'd0;
      redir.redir_valid <= 1'b0;
      redir.redir_pc    <= 32'd0;
      flush             <= 1'b0;
      misalign_exc      <= 1'b0;
      misalign_tval     <= 32'd0;
    end else begin
      misalign_exc <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && taken) begin
            if (misaligned) begin
              misalign_exc  <= 1'b1;
              misalign_tval <= target;
            end else begin
              state             <= REDIRECT;
              redir.redir_valid <= 1'b1;
              redir.redir_pc    <= target;
              flush             <= 1'b1;
            end
          end
        end
        REDIRECT: begin
          if (redir.redir_ready) begin
            state             <= DRAIN;
            redir.redir_valid <= 1'b0;
            drain_cnt         <= 4'(FETCH_LAT);
            flush             <= 1'b1;
          end else begin
            flush <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt <= 4'd1) begin
            state     <= IDLE;
            drain_cnt <= 4'd0;
            flush     <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: begin
          state             <= IDLE;
          redir.redir_valid <= 1'b0;
          flush             <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= 32'd0;
      stat_taken    <= 32'd0;
      stat_stall    <= 32'd0;
    end else begin
      if (br_en && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (accept && taken && !misaligned && (stat_taken != 32'hFFFF_FFFF))
        stat_taken <= stat_taken + 32'd1;
      if ((state != IDLE) && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  assign stat_branches = 32'd0;
  assign stat_taken    = 32'd0;
  assign stat_stall    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl (FETCH_LAT=1 and FETCH_LAT=3)
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid1, ex_valid3;
  logic        ex_is_branch, ex_is_jal, ex_is_jalr, br_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;

  logic        ex_ready1, br_en1, flush1, misalign_exc1;
  logic [2:0]  br_funct3_1;
  logic [31:0] br_data_a1, br_data_b1, link_data1, misalign_tval1;
  logic [31:0] stat_branches1, stat_taken1, stat_stall1;

  logic        ex_ready3, br_en3, flush3, misalign_exc3;
  logic [2:0]  br_funct3_3;
  logic [31:0] br_data_a3, br_data_b3, link_data3, misalign_tval3;
  logic [31:0] stat_branches3, stat_taken3, stat_stall3;

  branch_ctrl_if rif1();
  branch_ctrl_if rif3();

  branch_ctrl #(.FETCH_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid1), .ex_ready(ex_ready1),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .br_en(br_en1), .br_funct3(br_funct3_1), .br_data_a(br_data_a1), .br_data_b(br_data_b1),
    .br_taken(br_taken), .link_data(link_data1),
    .redir(rif1.master),
    .flush(flush1), .misalign_exc(misalign_exc1), .misalign_tval(misalign_tval1),
    .stat_branches(stat_branches1), .stat_taken(stat_taken1), .stat_stall(stat_stall1)
  );

  branch_ctrl #(.FETCH_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid3), .ex_ready(ex_ready3),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .br_en(br_en3), .br_funct3(br_funct3_3), .br_data_a(br_data_a3), .br_data_b(br_data_b3),
    .br_taken(br_taken), .link_data(link_data3),
    .redir(rif3.master),
    .flush(flush3), .misalign_exc(misalign_exc3), .misalign_tval(misalign_tval3),
    .stat_branches(stat_branches3), .stat_taken(stat_taken3), .stat_stall(stat_stall3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid1    = 1'b0;
    ex_valid3    = 1'b0;
    ex_is_branch = 1'b0;
    ex_is_jal    = 1'b0;
    ex_is_jalr   = 1'b0;
    ex_funct3    = 3'd0;
    ex_pc        = 32'd0;
    ex_imm       = 32'd0;
    ex_rs1_data  = 32'd0;
    ex_rs2_data  = 32'd0;
    br_taken     = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rif1.redir_ready = 1'b0;
    rif3.redir_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_ex_ready", 32'(ex_ready1), 32'd1);
    chk("rst_redir_valid", 32'(rif1.redir_valid), 32'd0);
    chk("rst_redir_pc", rif1.redir_pc, 32'd0);
    chk("rst_flush", 32'(flush1), 32'd0);
    chk("rst_misalign_exc", 32'(misalign_exc1), 32'd0);
    chk("rst_misalign_tval", misalign_tval1, 32'd0);
    chk("rst_stat_stall", stat_stall1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // BEQ taken, fetch ready immediately
    ex_valid1 = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'd0;
    ex_pc = 32'h100; ex_imm = 32'h20; ex_rs1_data = 32'd5; ex_rs2_data = 32'd5;
    br_taken = 1'b1; rif1.redir_ready = 1'b1;
    #1;
    chk("beq_br_en", 32'(br_en1), 32'd1);
    chk("beq_br_funct3", 32'(br_funct3_1), 32'd0);
    chk("beq_data_a", br_data_a1, 32'd5);
    chk("beq_data_b", br_data_b1, 32'd5);
    chk("beq_link", link_data1, 32'h104);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("beq_redir_valid", 32'(rif1.redir_valid), 32'd1);
    chk("beq_redir_pc", rif1.redir_pc, 32'h120);
    chk("beq_flush", 32'(flush1), 32'd1);
    chk("beq_ex_ready_redir", 32'(ex_ready1), 32'd0);
    @(negedge clk);
    chk("beq_drain_valid", 32'(rif1.redir_valid), 32'd0);
    chk("beq_drain_flush", 32'(flush1), 32'd1);
    chk("beq_drain_ready", 32'(ex_ready1), 32'd0);
    @(negedge clk);
    chk("beq_idle_ready", 32'(ex_ready1), 32'd1);
    chk("beq_idle_flush", 32'(flush1), 32'd0);

    // BNE not taken
    ex_valid1 = 1'b1; ex_is_branch = 1'b1; ex_funct3 = 3'd1;
    ex_pc = 32'h200; ex_imm = 32'h40; ex_rs1_data = 32'd1; ex_rs2_data = 32'd2;
    br_taken = 1'b0;
    #1;
    chk("bne_br_en", 32'(br_en1), 32'd1);
    chk("bne_br_funct3", 32'(br_funct3_1), 32'd1);
    chk("bne_data_b", br_data_b1, 32'd2);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("bne_br_en_off", 32'(br_en1), 32'd0);
    chk("bne_no_redir", 32'(rif1.redir_valid), 32'd0);
    chk("bne_no_flush", 32'(flush1), 32'd0);
    chk("bne_ex_ready", 32'(ex_ready1), 32'd1);

    // JALR with stalled fetch, then a held BEQ accepted back-to-back
    rif1.redir_ready = 1'b0;
    ex_valid1 = 1'b1; ex_is_jalr = 1'b1;
    ex_pc = 32'h400; ex_rs1_data = 32'h1001; ex_imm = 32'h4;
    #1;
    chk("jalr_link", link_data1, 32'h404);
    chk("jalr_br_en", 32'(br_en1), 32'd0);
    @(negedge clk);
    ex_is_jalr = 1'b0; ex_is_branch = 1'b1; ex_funct3 = 3'd0;
    ex_pc = 32'h1004; ex_imm = 32'h10; br_taken = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("jalr_hold_valid", 32'(rif1.redir_valid), 32'd1);
      chk("jalr_hold_pc", rif1.redir_pc, 32'h1004);
      chk("jalr_hold_ready", 32'(ex_ready1), 32'd0);
      chk("jalr_hold_br_en", 32'(br_en1), 32'd0);
      chk("jalr_hold_flush", 32'(flush1), (k == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    chk("jalr_still_valid", 32'(rif1.redir_valid), 32'd1);
    rif1.redir_ready = 1'b1;
    @(negedge clk);
    chk("jalr_drain_valid", 32'(rif1.redir_valid), 32'd0);
    chk("jalr_drain_flush", 32'(flush1), 32'd1);
    chk("jalr_drain_br_en", 32'(br_en1), 32'd0);
    @(negedge clk);
    #1;
    chk("b2b_ready", 32'(ex_ready1), 32'd1);
    chk("b2b_br_en", 32'(br_en1), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("b2b_redir_valid", 32'(rif1.redir_valid), 32'd1);
    chk("b2b_redir_pc", rif1.redir_pc, 32'h1014);
    repeat (2) @(negedge clk);
    chk("b2b_back_idle", 32'(ex_ready1), 32'd1);

    // JAL to misaligned target
    ex_valid1 = 1'b1; ex_is_jal = 1'b1; ex_pc = 32'h300; ex_imm = 32'h6;
    #1;
    chk("jal_ex_ready", 32'(ex_ready1), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mis_exc", 32'(misalign_exc1), 32'd1);
    chk("mis_tval", misalign_tval1, 32'h306);
    chk("mis_no_redir", 32'(rif1.redir_valid), 32'd0);
    chk("mis_no_flush", 32'(flush1), 32'd0);
    chk("mis_ex_ready", 32'(ex_ready1), 32'd1);
    @(negedge clk);
    chk("mis_exc_pulse", 32'(misalign_exc1), 32'd0);

    // link_data wraps modulo 2^32
    ex_pc = 32'hFFFF_FFFC;
    #1;
    chk("link_wrap", link_data1, 32'd0);
    idle_inputs();

    // FETCH_LAT=3: three drain cycles
    rif3.redir_ready = 1'b1;
    ex_valid3 = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h500; ex_imm = 32'h40; br_taken = 1'b1;
    #1;
    chk("fl3_br_en", 32'(br_en3), 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("fl3_redir_valid", 32'(rif3.redir_valid), 32'd1);
    chk("fl3_redir_pc", rif3.redir_pc, 32'h540);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fl3_drain_ready", 32'(ex_ready3), 32'd0);
      chk("fl3_drain_flush", 32'(flush3), 32'd1);
      chk("fl3_drain_valid", 32'(rif3.redir_valid), 32'd0);
    end
    @(negedge clk);
    chk("fl3_idle_ready", 32'(ex_ready3), 32'd1);
    chk("fl3_idle_flush", 32'(flush3), 32'd0);

    // FETCH_LAT=3: async reset in the middle of DRAIN
    ex_valid3 = 1'b1; ex_is_branch = 1'b1; ex_pc = 32'h600; ex_imm = 32'h80; br_taken = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("arst_pre_flush", 32'(flush3), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_redir_valid", 32'(rif3.redir_valid), 32'd0);
    chk("arst_redir_pc", rif3.redir_pc, 32'd0);
    chk("arst_flush", 32'(flush3), 32'd0);
    chk("arst_ex_ready", 32'(ex_ready3), 32'd1);
    chk("arst_tval_dut1", misalign_tval1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_after_ready", 32'(ex_ready3), 32'd1);
    chk("arst_after_valid", 32'(rif3.redir_valid), 32'd0);
    chk("arst_after_flush", 32'(flush3), 32'd0);

    // statistics: four branches, two taken, fetch ready two cycles late
    for (int i = 0; i < 4; i++) begin
      rif1.redir_ready = 1'b0;
      ex_valid1 = 1'b1; ex_is_branch = 1'b1;
      ex_pc = 32'h700 + 32'(i) * 32'h10; ex_imm = 32'h20;
      br_taken = ((i % 2) == 0);
      @(negedge clk);
      idle_inputs();
      if ((i % 2) == 0) begin
        repeat (2) @(negedge clk);
        rif1.redir_ready = 1'b1;
        repeat (2) @(negedge clk);
      end
      chk("stats_loop_ready", 32'(ex_ready1), 32'd1);
    end
`ifdef BRANCH_CTRL_STATS_EN
    chk("stat_branches", stat_branches1, 32'd4);
    chk("stat_taken", stat_taken1, 32'd2);
    chk("stat_stall", stat_stall1, 32'd8);
`else
    chk("stat_branches_off", stat_branches1, 32'd0);
    chk("stat_taken_off", stat_taken1, 32'd0);
    chk("stat_stall_off", stat_stall1, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
